int_img_rect_reader: RTL and testbench

- Reader side of the integral-image buffer filled by int_img_calc.
- Accepts one rectangle request (x, y, w, h) through a valid/ready handshake.
- Issues four corner reads to the integral-image RAM and, in parallel, to the squared integral-image RAM.
- Returns the rectangle sum and the squared-pixel sum. These feed the feature accumulators and the window std-dev computation.

---
 rtl/vj_int_img_pkg.sv | 33 +++
 rtl/int_img_rect_reader_if.sv | 42 ++++
 rtl/int_img_addr.sv | 18 +
 rtl/int_img_rect_reader.sv | 167 ++++++++++++++++
 tb/tb_int_img_rect_reader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vj_int_img_pkg.sv
// rtl/vj_int_img_pkg.sv - shared types and defaults for the integral-image buffer
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 24
`endif

package vj_int_img_pkg;

    localparam int PKG_IMG_WIDTH  = `WINDOW_SIZE;
    localparam int PKG_IMG_HEIGHT = `WINDOW_SIZE;
    localparam int PKG_DATA_W     = 32;
    localparam int PKG_COORD_W    = 5;
    localparam int PKG_ADDR_W     = 10;

    // One rectangle request in pixel coordinates
    typedef struct packed {
        logic [PKG_COORD_W-1:0] x;
        logic [PKG_COORD_W-1:0] y;
        logic [PKG_COORD_W-1:0] w;
        logic [PKG_COORD_W-1:0] h;
    } rect_req_t;

    // Reader sequence: four corner reads, one drain cycle for the last word, then respond
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_D  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_RD_C  = 3'd3,
        ST_RD_A  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_RESP  = 3'd6
    } rd_state_e;

endpackage

// File: rtl/int_img_rect_reader_if.sv
// rtl/int_img_rect_reader_if.sv - request, RAM and response bundle of the rectangle reader
interface int_img_rect_reader_if #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 5,
    parameter int ADDR_W  = 10
);
    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic [COORD_W-1:0] req_w;
    logic [COORD_W-1:0] req_h;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_rdata;
    logic [DATA_W-1:0]  mem_sq_rdata;
    logic               resp_valid;
    logic               resp_ready;
    logic [DATA_W-1:0]  resp_sum;
    logic [DATA_W-1:0]  resp_sq_sum;
    logic               resp_err;

    // Requester / RAM / consumer side
    modport master (
        output req_valid, req_x, req_y, req_w, req_h,
        input  req_ready,
        input  mem_rd_en, mem_addr,
        output mem_rdata, mem_sq_rdata,
        input  resp_valid, resp_sum, resp_sq_sum, resp_err,
        output resp_ready
    );

    // Reader side
    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h,
        output req_ready,
        output mem_rd_en, mem_addr,
        input  mem_rdata, mem_sq_rdata,
        output resp_valid, resp_sum, resp_sq_sum, resp_err,
        input  resp_ready
    );
endinterface

// File: rtl/int_img_addr.sv
// rtl/int_img_addr.sv - (row, col) to integral-image word address
module int_img_addr #(
    parameter int IMG_WIDTH = 24,
    parameter int POS_W     = 6,
    parameter int ADDR_W    = 10
) (
    input  logic [POS_W-1:0]  row_i,
    input  logic [POS_W-1:0]  col_i,
    output logic [ADDR_W-1:0] addr_o
);
    // Integral rows are one word wider than the image because column 0 is the zero column
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_WIDTH + 1);

    // Row-major linear address
    always_comb begin
        addr_o = ADDR_W'(row_i) * STRIDE + ADDR_W'(col_i);
    end
endmodule

// File: rtl/int_img_rect_reader.sv
// rtl/int_img_rect_reader.sv - four-corner rectangle sum reader over integral and squared-integral RAMs
module int_img_rect_reader
    import vj_int_img_pkg::*;
#(
    parameter int IMG_WIDTH  = PKG_IMG_WIDTH,
    parameter int IMG_HEIGHT = PKG_IMG_HEIGHT,
    parameter int DATA_W     = PKG_DATA_W,
    parameter int COORD_W    = PKG_COORD_W,
    parameter int ADDR_W     = PKG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    int_img_rect_reader_if.slave  bus
);
    // Corner coordinates need one extra bit because x+w can exceed the field range
    localparam int POS_W = COORD_W + 1;
    localparam logic [POS_W-1:0] X_LIMIT = POS_W'(IMG_WIDTH);
    localparam logic [POS_W-1:0] Y_LIMIT = POS_W'(IMG_HEIGHT);

    rd_state_e         state_q, state_d;
    rect_req_t         req_q, req_d;
    logic [POS_W-1:0]  x_end_q, x_end_d;
    logic [POS_W-1:0]  y_end_q, y_end_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] sq_acc_q, sq_acc_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_bad;
    logic [POS_W-1:0]  in_x_end;
    logic [POS_W-1:0]  in_y_end;
    logic [POS_W-1:0]  row_sel;
    logic [POS_W-1:0]  col_sel;

    assign in_x_end = POS_W'(bus.req_x) + POS_W'(bus.req_w);
    assign in_y_end = POS_W'(bus.req_y) + POS_W'(bus.req_h);
    assign req_bad  = (bus.req_w == '0) || (bus.req_h == '0) ||
                      (in_x_end > X_LIMIT) || (in_y_end > Y_LIMIT);
    assign accept   = bus.req_valid && bus.req_ready;

    int_img_addr #(
        .IMG_WIDTH (IMG_WIDTH),
        .POS_W     (POS_W),
        .ADDR_W    (ADDR_W)
    ) u_addr (
        .row_i  (row_sel),
        .col_i  (col_sel),
        .addr_o (bus.mem_addr)
    );

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: bad requests skip the reads and respond immediately
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = req_bad ? ST_RESP : ST_RD_D;
            ST_RD_D:  state_d = ST_RD_B;
            ST_RD_B:  state_d = ST_RD_C;
            ST_RD_C:  state_d = ST_RD_A;
            ST_RD_A:  state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP:  if (bus.resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: read strobe and corner selection per state; address is zero when not reading
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE) && !reset;
        bus.mem_rd_en  = 1'b0;
        bus.resp_valid = (state_q == ST_RESP);
        row_sel        = '0;
        col_sel        = '0;
        case (state_q)
            ST_RD_D: begin
                bus.mem_rd_en = 1'b1;
                row_sel       = y_end_q;
                col_sel       = x_end_q;
            end
            ST_RD_B: begin
                bus.mem_rd_en = 1'b1;
                row_sel       = POS_W'(req_q.y);
                col_sel       = x_end_q;
            end
            ST_RD_C: begin
                bus.mem_rd_en = 1'b1;
                row_sel       = y_end_q;
                col_sel       = POS_W'(req_q.x);
            end
            ST_RD_A: begin
                bus.mem_rd_en = 1'b1;
                row_sel       = POS_W'(req_q.y);
                col_sel       = POS_W'(req_q.x);
            end
            default: ;
        endcase
    end

    assign bus.resp_sum    = acc_q;
    assign bus.resp_sq_sum = sq_acc_q;
    assign bus.resp_err    = err_q;

    // Datapath next-state: capture on accept, then fold each returning word in as +D -B -C +A
    always_comb begin
        req_d    = req_q;
        x_end_d  = x_end_q;
        y_end_d  = y_end_q;
        acc_d    = acc_q;
        sq_acc_d = sq_acc_q;
        err_d    = err_q;
        if (accept) begin
            req_d.x  = bus.req_x;
            req_d.y  = bus.req_y;
            req_d.w  = bus.req_w;
            req_d.h  = bus.req_h;
            x_end_d  = in_x_end;
            y_end_d  = in_y_end;
            acc_d    = '0;
            sq_acc_d = '0;
            err_d    = req_bad;
        end else begin
            case (state_q)
                // Data for the read issued in the previous state is on the bus now
                ST_RD_B: begin
                    acc_d    = acc_q + bus.mem_rdata;
                    sq_acc_d = sq_acc_q + bus.mem_sq_rdata;
                end
                ST_RD_C, ST_RD_A: begin
                    acc_d    = acc_q - bus.mem_rdata;
                    sq_acc_d = sq_acc_q - bus.mem_sq_rdata;
                end
                ST_DRAIN: begin
                    acc_d    = acc_q + bus.mem_rdata;
                    sq_acc_d = sq_acc_q + bus.mem_sq_rdata;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q    <= '0;
            x_end_q  <= '0;
            y_end_q  <= '0;
            acc_q    <= '0;
            sq_acc_q <= '0;
            err_q    <= 1'b0;
        end else begin
            req_q    <= req_d;
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
            acc_q    <= acc_d;
            sq_acc_q <= sq_acc_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_int_img_rect_reader.sv
// tb/tb_int_img_rect_reader.sv - self-checking bench for int_img_rect_reader
module tb_int_img_rect_reader;
    localparam int W  = 24;
    localparam int H  = 24;
    localparam int ST = W + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int_img_rect_reader_if #(.DATA_W(32), .COORD_W(5), .ADDR_W(10)) bus ();

    int_img_rect_reader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          pix [H][W];
    logic [31:0] ram    [1024];
    logic [31:0] ram_sq [1024];
    int          addr_q [$];

    bit          exp_active = 1'b0;
    logic [31:0] exp_sum    = '0;
    logic [31:0] exp_sq     = '0;
    logic        exp_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // RAM model with one-cycle read latency
    always @(posedge clock) begin
        if (bus.mem_rd_en) begin
            bus.mem_rdata    <= ram[bus.mem_addr];
            bus.mem_sq_rdata <= ram_sq[bus.mem_addr];
        end
    end

    // Record every issued read address
    always @(negedge clock) begin
        if (!reset && bus.mem_rd_en) addr_q.push_back(int'(bus.mem_addr));
    end

    // Compare process: response fields against the model whenever a response is shown
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.resp_valid) begin
                chk("resp_expected", {31'd0, exp_active}, 32'd1);
                chk("resp_sum", bus.resp_sum, exp_sum);
                chk("resp_sq_sum", bus.resp_sq_sum, exp_sq);
                chk("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err});
            end
            if (exp_active && exp_err && bus.mem_rd_en)
                chk("rd_on_err", {31'd0, bus.mem_rd_en}, 32'd0);
        end
    end

    // mode 0: all 2, mode 1: all 255, mode 2: random bytes
    task automatic load_image(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pix[r][c] = (mode == 0) ? 2 : (mode == 1) ? 255 : int'($urandom_range(0, 255));
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = '0;
            ram_sq[i] = '0;
        end
        for (int r = 1; r <= H; r++)
            for (int c = 1; c <= W; c++) begin
                ram[r*ST+c] = 32'(pix[r-1][c-1]) + ram[(r-1)*ST+c] + ram[r*ST+c-1] - ram[(r-1)*ST+c-1];
                ram_sq[r*ST+c] = 32'(pix[r-1][c-1] * pix[r-1][c-1]) + ram_sq[(r-1)*ST+c]
                               + ram_sq[r*ST+c-1] - ram_sq[(r-1)*ST+c-1];
            end
    endtask

    // Reference: direct pixel summation over the rectangle
    task automatic model(input int x, input int y, input int w, input int h,
                         output logic [31:0] s, output logic [31:0] sq, output logic e);
        s  = '0;
        sq = '0;
        e  = (w == 0) || (h == 0) || (x + w > W) || (y + h > H);
        if (!e)
            for (int r = y; r < y + h; r++)
                for (int c = x; c < x + w; c++) begin
                    s  = s + 32'(pix[r][c]);
                    sq = sq + 32'(pix[r][c] * pix[r][c]);
                end
    endtask

    task automatic run_req(input int x, input int y, input int w, input int h, input int hold,
                           input bit lit_en, input logic [31:0] lit_sum, input logic [31:0] lit_sq,
                           input logic lit_err);
        logic [31:0] ms, msq;
        logic        me;
        int          lat;
        int          exp_addr [4];
        model(x, y, w, h, ms, msq, me);
        if (lit_en) begin
            chk("model_sum", ms, lit_sum);
            chk("model_sq", msq, lit_sq);
            chk("model_err", {31'd0, me}, {31'd0, lit_err});
        end
        exp_sum = ms;
        exp_sq  = msq;
        exp_err = me;
        addr_q.delete();
        @(negedge clock);
        bus.req_x     = 5'(x);
        bus.req_y     = 5'(y);
        bus.req_w     = 5'(w);
        bus.req_h     = 5'(h);
        bus.req_valid = 1'b1;
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clock);
        #1;
        exp_active    = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_x     = 5'($urandom);
        bus.req_w     = 5'($urandom);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), me ? 32'd1 : 32'd6);
        for (int j = 0; j < hold; j++) begin
            chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clock);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b0;
        exp_active     = 1'b0;
        @(negedge clock);
        chk("valid_after_hs", {31'd0, bus.resp_valid}, 32'd0);
        chk("ready_after_hs", {31'd0, bus.req_ready}, 32'd1);
        if (me) begin
            chk("n_reads_err", 32'(addr_q.size()), 32'd0);
        end else begin
            exp_addr[0] = (y + h) * ST + (x + w);
            exp_addr[1] = y * ST + (x + w);
            exp_addr[2] = (y + h) * ST + x;
            exp_addr[3] = y * ST + x;
            chk("n_reads", 32'(addr_q.size()), 32'd4);
            if (addr_q.size() == 4)
                for (int i = 0; i < 4; i++) chk("rd_addr", 32'(addr_q[i]), 32'(exp_addr[i]));
        end
    endtask

    initial begin
        logic [31:0] s, sq;
        logic        e;
        int          rx, ry, rw, rh;
        bus.req_valid    = 1'b0;
        bus.req_x        = '0;
        bus.req_y        = '0;
        bus.req_w        = '0;
        bus.req_h        = '0;
        bus.resp_ready   = 1'b0;
        bus.mem_rdata    = '0;
        bus.mem_sq_rdata = '0;
        load_image(0);

        repeat (3) @(negedge clock);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post_rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("post_rst_sum", bus.resp_sum, 32'd0);
        chk("post_rst_sq", bus.resp_sq_sum, 32'd0);
        chk("post_rst_err", {31'd0, bus.resp_err}, 32'd0);

        run_req(0, 0, 6, 6, 0, 1'b1, 32'd72, 32'd144, 1'b0);
        run_req(4, 4, 4, 4, 0, 1'b1, 32'd32, 32'd64, 1'b0);
        run_req(0, 0, 24, 24, 0, 1'b1, 32'd1152, 32'd2304, 1'b0);
        run_req(20, 0, 6, 1, 0, 1'b1, 32'd0, 32'd0, 1'b1);
        run_req(3, 3, 0, 5, 0, 1'b1, 32'd0, 32'd0, 1'b1);
        run_req(0, 20, 3, 5, 0, 1'b1, 32'd0, 32'd0, 1'b1);
        run_req(18, 19, 6, 5, 0, 1'b1, 32'd60, 32'd120, 1'b0);
        run_req(4, 4, 4, 4, 3, 1'b1, 32'd32, 32'd64, 1'b0);

        // Reset while the B corner is being read
        @(negedge clock);
        bus.req_x = 5'd2; bus.req_y = 5'd3; bus.req_w = 5'd5; bus.req_h = 5'd6;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rd_b_active", {31'd0, bus.mem_rd_en}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("after_mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (8) @(negedge clock);
        run_req(4, 4, 4, 4, 0, 1'b1, 32'd32, 32'd64, 1'b0);

        // Random pixels, random rectangles against the summation model
        load_image(2);
        for (int k = 0; k < 12; k++) begin
            rx = int'($urandom_range(0, W - 1));
            ry = int'($urandom_range(0, H - 1));
            rw = int'($urandom_range(1, W - rx));
            rh = int'($urandom_range(1, H - ry));
            run_req(rx, ry, rw, rh, int'($urandom_range(0, 2)), 1'b0, '0, '0, 1'b0);
        end
        run_req(5, 5, 20, 2, 0, 1'b0, '0, '0, 1'b0);

        // Saturated image, full window
        load_image(1);
        model(0, 0, 24, 24, s, sq, e);
        run_req(0, 0, 24, 24, 1, 1'b1, 32'd146880, 32'd37454400, 1'b0);
        run_req(10, 7, 3, 9, 0, 1'b1, 32'd6885, 32'd1755675, 1'b0);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end
endmodule
